// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the serial BCD adder
package bcd_pkg;

    localparam int BCD_W   = 4;
    localparam int BCD_MAX = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - one-digit decimal adder with +6 correction
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    input  logic             cin,
    output logic [BCD_W-1:0] digit,
    output logic             cout
);

    logic [BCD_W:0] s;
    logic [BCD_W:0] s_adj;

    // Five bits are enough even for out-of-range digits (15 + 15 + 1).
    assign s     = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
    assign s_adj = s + (BCD_W + 1)'(6);

    always_comb begin
        digit = s[BCD_W-1:0];
        cout  = 1'b0;
        if (s > (BCD_W + 1)'(BCD_MAX)) begin
            digit = s_adj[BCD_W-1:0];
            cout  = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial BCD add/subtract, one digit per clock
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    Start,
    input  logic                    Sub,
    input  logic                    Cin,
    input  logic [BCD_W*DIGITS-1:0] A,
    input  logic [BCD_W*DIGITS-1:0] B,
    output logic                    Ready,
    output logic                    Done,
    output logic [BCD_W*DIGITS-1:0] Sum,
    output logic                    Carry,
    output logic                    Error
);

    localparam int W     = BCD_W * DIGITS;
    localparam int IDX_W = $clog2(DIGITS) + 1;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [W-1:0]       sum_r;
    logic               sub_r;
    logic               carry_r;
    logic               err_r;

    logic               accept;
    logic               last;
    logic               in_err;
    logic [BCD_W-1:0]   a_dig;
    logic [BCD_W-1:0]   b_dig;
    logic [BCD_W-1:0]   b_eff;
    logic [BCD_W-1:0]   dig;
    logic               cout;

    assign accept = (state == IDLE) && Start;
    assign last   = (idx == IDX_W'(DIGITS - 1));

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (A[i*BCD_W +: BCD_W] > BCD_W'(BCD_MAX) ||
                B[i*BCD_W +: BCD_W] > BCD_W'(BCD_MAX))
                in_err = 1'b1;
        end
    end

    // Subtraction uses the nines' complement of B plus an initial carry of one.
    assign a_dig = a_r[idx*BCD_W +: BCD_W];
    assign b_dig = b_r[idx*BCD_W +: BCD_W];
    assign b_eff = sub_r ? (BCD_W'(BCD_MAX) - b_dig) : b_dig;

    bcd_digit_add u_digit (
        .a     (a_dig),
        .b     (b_eff),
        .cin   (carry_r),
        .digit (dig),
        .cout  (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sub_r   <= 1'b0;
            sum_r   <= '0;
            idx     <= '0;
            carry_r <= 1'b0;
            err_r   <= 1'b0;
        end else if (accept) begin
            a_r     <= A;
            b_r     <= B;
            sub_r   <= Sub;
            sum_r   <= '0;
            idx     <= '0;
            carry_r <= Sub ? 1'b1 : Cin;
            err_r   <= in_err;
        end else if (state == RUN) begin
            sum_r[idx*BCD_W +: BCD_W] <= dig;
            carry_r                   <= cout;
            idx                       <= idx + 1'b1;
        end
    end

    assign Ready = (state == IDLE);
    assign Done  = (state == DONE);
    assign Sum   = sum_r;
    assign Carry = carry_r;
    assign Error = err_r;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - self-checking bench for bcd_serial_adder
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic        Sub;
    logic        Cin;
    logic [15:0] A;
    logic [15:0] B;
    logic        Ready;
    logic        Done;
    logic [15:0] Sum;
    logic        Carry;
    logic        Error;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Start (Start),
        .Sub   (Sub),
        .Cin   (Cin),
        .A     (A),
        .B     (B),
        .Ready (Ready),
        .Done  (Done),
        .Sum   (Sum),
        .Carry (Carry),
        .Error (Error)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result of the digit rule applied to whole operands: {carry, sum}.
    function automatic logic [16:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                          input logic sub, input logic cin);
        int c, s, ad, bd;
        logic [15:0] r;
        r = '0;
        c = sub ? 1 : int'(cin);
        for (int i = 0; i < DIGITS; i++) begin
            ad = int'(a[4*i +: 4]);
            bd = int'(b[4*i +: 4]);
            if (sub) bd = (9 - bd) & 15;
            s = ad + bd + c;
            if (s > 9) begin r[4*i +: 4] = 4'((s + 6) & 15); c = 1; end
            else       begin r[4*i +: 4] = 4'(s);            c = 0; end
        end
        return {1'(c), r};
    endfunction

    function automatic bit has_bad(input logic [15:0] v);
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1;
        return 0;
    endfunction

    function automatic int to_dec(input logic [15:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < DIGITS; i++) begin r[4*i +: 4] = 4'(v % 10); v = v / 10; end
        return r;
    endfunction

    function automatic logic [15:0] rand_bcd(input bit allow_bad);
        logic [15:0] r;
        for (int i = 0; i < DIGITS; i++)
            r[4*i +: 4] = (allow_bad && ($urandom % 8 == 0)) ? 4'(10 + $urandom % 6) : 4'($urandom % 10);
        return r;
    endfunction

    // Cycle model: m_pos = edges since accept (-1 when idle); DIGITS means the Done cycle.
    int          m_pos;
    logic [15:0] m_res;
    logic        m_rc, m_carry, m_err;
    logic [15:0] es;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos <= -1; m_res <= '0; m_rc <= 0; m_carry <= 0; m_err <= 0;
        end else if (m_pos < 0) begin
            if (Start) begin
                {m_rc, m_res} <= ref_op(A, B, Sub, Cin);
                m_err         <= has_bad(A) | has_bad(B);
                m_pos         <= 0;
            end
        end else if (m_pos == DIGITS) begin
            m_pos <= -1;
        end else begin
            m_pos <= m_pos + 1;
            if (m_pos + 1 == DIGITS) m_carry <= m_rc;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            es = m_res;
            if (m_pos >= 0)
                for (int i = 0; i < DIGITS; i++) if (i >= m_pos) es[4*i +: 4] = 4'h0;
            check("cyc_ready", Ready, m_pos < 0);
            check("cyc_done", Done, m_pos == DIGITS);
            check("cyc_error", Error, m_err);
            check("cyc_sum", Sum, es);
            if (m_pos < 0 || m_pos == DIGITS) check("cyc_carry", Carry, m_carry);
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input logic cin, input bit stray, output logic [15:0] s,
                          output logic c, output logic e, output int lat);
        int n = 0;
        while (!Ready && n < 30) begin @(negedge clk); n++; end
        if (!Ready) check("ready_timeout", 0, 1);
        A = a; B = b; Sub = sub; Cin = cin; Start = 1;
        @(negedge clk);
        Start = 0; A = 16'($urandom); B = 16'($urandom); Sub = 1'($urandom); Cin = 1'($urandom);
        lat = 0;
        do begin
            Start = stray ? 1'($urandom) : 1'b0;
            @(negedge clk);
            lat++;
        end while (!Done && lat < 30);
        Start = 0;
        if (!Done) check("done_timeout", 0, 1);
        s = Sum; c = Carry; e = Error;
    endtask

    logic [15:0] rs, ra, rb;
    logic        rc, re, rsub, rcin;
    int          lat, n, exp_v, t0, t1, t2;
    bit          saw;
    logic [15:0] ha [3] = '{16'h1111, 16'h2222, 16'h9999};
    logic [15:0] hb [3] = '{16'h0123, 16'h4567, 16'h0001};
    logic [15:0] hs [3] = '{16'h1234, 16'h6789, 16'h0000};
    int          td [3];

    initial begin
        rst_n = 0; Start = 0; Sub = 0; Cin = 0; A = '0; B = '0;
        check("pin_model_add", ref_op(16'h0006, 16'h0006, 0, 0), 17'h00012);
        check("pin_model_sub", ref_op(16'h0005, 16'h0008, 1, 0), 17'h09997);
        repeat (3) @(negedge clk);
        check("rst_ready", Ready, 1); check("rst_done", Done, 0);
        check("rst_sum", Sum, 0); check("rst_carry", Carry, 0); check("rst_error", Error, 0);
        rst_n = 1; chk_en = 1;
        @(negedge clk);

        run_op(16'h0006, 16'h0006, 0, 0, 0, rs, rc, re, lat);
        check("add6_sum", rs, 16'h0012); check("add6_carry", rc, 0);
        check("add6_err", re, 0); check("add6_latency", lat, DIGITS);
        run_op(16'h9999, 16'h0001, 0, 0, 0, rs, rc, re, lat);
        check("wrap_sum", rs, 16'h0000); check("wrap_carry", rc, 1);
        run_op(16'h0000, 16'h0000, 0, 1, 0, rs, rc, re, lat);
        check("cin_sum", rs, 16'h0001);
        run_op(16'h0008, 16'h0005, 1, 0, 0, rs, rc, re, lat);
        check("sub_pos_sum", rs, 16'h0003); check("sub_pos_carry", rc, 1);
        run_op(16'h0005, 16'h0008, 1, 1, 0, rs, rc, re, lat);
        check("sub_neg_sum", rs, 16'h9997); check("sub_neg_carry", rc, 0);
        run_op(16'h000A, 16'h0001, 0, 0, 0, rs, rc, re, lat);
        check("bad_err", re, 1);
        @(negedge clk);
        check("bad_err_held", Error, 1);
        run_op(16'h0001, 16'h0001, 0, 0, 0, rs, rc, re, lat);
        check("err_cleared", re, 0); check("after_bad_sum", rs, 16'h0002);
        run_op(16'h1234, 16'h5678, 0, 0, 1, rs, rc, re, lat);
        check("stray_sum", rs, 16'h6912); check("stray_latency", lat, DIGITS);

        // Abort mid-run: reset after edge 2, Start held during reset must be ignored.
        while (!Ready) @(negedge clk);
        A = 16'h00B0; B = 16'h0001; Sub = 0; Cin = 0; Start = 1;
        @(posedge clk); @(negedge clk); Start = 0;
        @(posedge clk); @(posedge clk);
        #1 rst_n = 0; Start = 1;
        #1 check("abort_ready", Ready, 1); check("abort_sum", Sum, 0);
        check("abort_done", Done, 0); check("abort_err", Error, 0);
        @(negedge clk); @(negedge clk);
        check("rst_start_ignored", Ready, 1);
        Start = 0; rst_n = 1;
        saw = 0;
        repeat (8) begin @(negedge clk); if (Done || !Ready) saw = 1; end
        check("no_done_after_abort", saw, 0);

        // First accept happens on the first edge with rst_n=1 and Start=1.
        rst_n = 0; Start = 1; A = 16'h0002; B = 16'h0003; Sub = 0; Cin = 0;
        @(negedge clk); rst_n = 1;
        @(negedge clk); check("first_accept", Ready, 0); Start = 0;
        n = 0;
        while (!Done && n < 30) begin @(negedge clk); n++; end
        check("first_accept_sum", Sum, 16'h0005);

        // Start held high: back-to-back operations every DIGITS+2 cycles.
        @(negedge clk);
        A = ha[0]; B = hb[0]; Sub = 0; Cin = 0; Start = 1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!Done && n < 30);
            check("held_done", Done, 1);
            check("held_sum", Sum, hs[k]);
            td[k] = cyc;
            if (k < 2) begin A = ha[k+1]; B = hb[k+1]; end
        end
        Start = 0;
        check("held_spacing0", td[1] - td[0], DIGITS + 2);
        check("held_spacing1", td[2] - td[1], DIGITS + 2);

        // Random valid operands against plain decimal arithmetic.
        for (int k = 0; k < 25; k++) begin
            ra = rand_bcd(0); rb = rand_bcd(0); rsub = 1'($urandom); rcin = 1'($urandom);
            run_op(ra, rb, rsub, rcin, 1'($urandom), rs, rc, re, lat);
            if (rsub) exp_v = to_dec(ra) - to_dec(rb) + 10000;
            else      exp_v = to_dec(ra) + to_dec(rb) + int'(rcin);
            check("rand_dec_sum", rs, to_bcd(exp_v % 10000));
            check("rand_dec_carry", rc, exp_v >= 10000);
        end

        // Free-running random stimulus, including bad digits and short resets.
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            rst_n = ($urandom % 120 != 0);
            Start = ($urandom % 3 == 0);
            A = rand_bcd(1); B = rand_bcd(1); Sub = 1'($urandom); Cin = 1'($urandom);
        end
        @(negedge clk);
        rst_n = 1; Start = 0;
        repeat (DIGITS + 3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The block SHALL expose parameter DIGITS: default 4, legal range 1..16; the number of BCD digits per operand.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 Start  in  1  request a new operation; sampled only while Ready=1.
REQ-006 Sub  in  1  mode select: 0 = add (A+B+Cin), 1 = subtract (A-B, ten's complement).
REQ-007 Cin  in  1  carry-in for add mode; ignored in subtract mode.
REQ-008 A, B  in  4*DIGITS  packed BCD operands; digit 0 is bits [3:0].
REQ-009 Ready  out  1  high only in state IDLE.
REQ-010 Done  out  1  one-cycle pulse; result valid.
REQ-011 Sum  out  4*DIGITS  packed BCD result.
REQ-012 Carry  out  1  add: decimal carry-out; sub: 1 = A>=B, 0 = borrow.
REQ-013 Error  out  1  high when any latched operand digit is greater than 9.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
- IDLE->RUN: on Start=1.
- RUN->DONE: after the digit with index DIGITS-1 is processed.
- DONE->IDLE: unconditionally after one cycle.
REQ-015 At the accepting edge the block SHALL:
- latch A, B and Sub;
- clear Sum to 0, clear digit index to 0;
- set Error from the latched operands;
- set internal carry to Cin (add) or 1 (sub).
REQ-016 Each RUN edge SHALL process digit i, writing Sum[4i+3:4i] and the next carry:
- b' = B digit (add) or 9 - B digit (sub, 4-bit);
- s = a + b' + carry, computed 5 bits wide, range 0..19;
- if s > 9: digit = (s+6)[3:0], carry = 1; else digit = s[3:0], carry = 0.
REQ-017 Carry SHALL equal the final internal carry and SHALL be valid when Done=1.
REQ-018 Latency: Start accepted at edge 0 -> digit i written at edge i+1 -> Done high in the cycle after edge DIGITS.
REQ-019 The minimum issue interval SHALL be DIGITS+2 cycles; with Start held high, the next accept is at edge DIGITS+2.
REQ-020 Start while Ready=0 SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-021 A, B, Sub and Cin changing after acceptance SHALL NOT affect the operation in progress.
REQ-022 Invalid digits (>9) SHALL still be processed by the REQ-016 rule.
REQ-023 Error SHALL be held until the next accepted Start.
REQ-024 Sum, Carry and Error SHALL be held stable from Done until the next accepted Start.
REQ-025 In subtract mode with A<B, Sum SHALL equal 10^DIGITS + A - B.
REQ-026 Done SHALL never be asserted for more than one consecutive cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force:
- state IDLE (Ready=1), Done=0, Sum=0, Carry=0, Error=0;
- digit index and internal carry to 0.
REQ-028 Reset during RUN or DONE SHALL abort the operation with no Done pulse.
REQ-029 Start SHALL be ignored while rst_n=0.
REQ-030 The first accept after reset release SHALL occur on the first rising edge with rst_n=1 and Start=1.

Structure
REQ-031 Package bcd_pkg SHALL hold:
- the FSM state enum (IDLE, RUN, DONE);
- the constant BCD_W=4;
- the constant BCD_MAX=9.
REQ-032 The single-digit correction logic SHALL be one combinational sub-module, bcd_digit_add, with:
- inputs: 4-bit a, 4-bit b, cin;
- outputs: 4-bit digit, cout;
- one instance, used once per RUN cycle.
REQ-033 The digit index counter SHALL be $clog2(DIGITS)+1 bits wide.

Verification (DIGITS=4)
REQ-034 Add, A=0006, B=0006, Cin=0 -> Sum=0012, Carry=0, Error=0, Done in the cycle after edge 4.
REQ-035 Add, A=9999, B=0001, Cin=0 -> Sum=0000, Carry=1; A=0000, B=0000, Cin=1 -> Sum=0001.
REQ-036 Sub, A=0008, B=0005 -> Sum=0003, Carry=1; A=0005, B=0008 -> Sum=9997, Carry=0.
REQ-037 Add, A=000A (digit 0 = 1010), B=0001 -> Error=1; the next valid op clears Error to 0.
REQ-038 Start pulses during RUN -> ignored, the first result is unchanged; rst_n=0 after edge 2 -> Ready=1, Sum=0, no Done.
REQ-039 Start held high for 3 ops -> Done pulses 6 cycles apart, each one cycle wide, with the correct Sum for each op.
